pad_mux_sequencer: RTL and testbench
====================================

Name: pad_mux_sequencer

Overview:
- Sits between the APB pad-control registers and the pad ring's per-pad mux/config inputs (pad_mux_o, pad_cfg_o).
- Applies requested pad-function and pad-config changes glitch-free. Affected pads are first forced to output-disable for a settle period, then the new mux/config is switched in, then the force is held for a hold period before release.
- Only pads whose mux or config actually changes are disturbed.

Parameters:
- NPADS, 32, number of muxable pads.
- CFG_W, 6, pad config bits per pad.
- SETTLE_CYC, 4, cycles of forced OEN before the switch (>=1).
- HOLD_CYC, 2, cycles of forced OEN after the switch (>=1).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  synchronous active-low reset.
- mux_req_i  in  NPADS  requested pad_mux (1 = alternate function), level from register.
- cfg_req_i  in  NPADS*CFG_W  requested pad_cfg, packed, pad i at [i*CFG_W +: CFG_W].
- pad_mux_o  out  NPADS  applied mux to pad ring.
- pad_cfg_o  out  NPADS*CFG_W  applied config to pad ring.
- oen_force_o  out  NPADS  1 = pad output forced disabled (ORed into pad OEN externally).
- busy_o  out  1  sequence in progress.

Behaviour:
- Reset (rst_n=0 at a clk edge): pad_mux_o=0, pad_cfg_o=0, oen_force_o=0, busy_o=0, state=IDLE, counter=0. Reset is synchronous only; it takes effect at the next edge, including in the middle of a sequence.
- Per-pad change mask: chg[i] = (mux_req_i[i]!=pad_mux_o[i]) | (cfg_req_i pad i != pad_cfg_o pad i).
- IDLE:
  - If |chg, snapshot mux_req_i, cfg_req_i and chg into mux_snap, cfg_snap and mask; go to SETTLE.
  - Next cycle: oen_force_o=mask, busy_o=1, counter=SETTLE_CYC-1.
- SETTLE: decrement the counter. When counter==0, go to SWITCH.
- SWITCH (one cycle): pad_mux_o<=mux_snap, pad_cfg_o<=cfg_snap; counter<=HOLD_CYC-1; go to HOLD. oen_force_o stays equal to mask.
- HOLD: decrement the counter. When counter==0, go to IDLE: oen_force_o<=0, busy_o<=0.
- Latency, request change to new pad_mux_o visible: 1 (snapshot) + SETTLE_CYC + 1 cycles.
- oen_force_o is asserted for SETTLE_CYC+1+HOLD_CYC cycles.
- Requests that change while busy are ignored for the current sequence. They are re-evaluated in IDLE and start a new sequence after the current one completes.
- There is no back-to-back bubble requirement beyond the single IDLE cycle.
- Pads not in mask keep oen_force_o=0 and keep their mux/config throughout.
- A request that returns to the applied values before IDLE samples it produces no sequence.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Counter width is $clog2(max(SETTLE_CYC,HOLD_CYC)+1).

Optional Feature:
- Macro PAD_MUX_SEQ_DONE_IRQ_EN.
- When defined:
  - Adds output done_o (1 bit), registered, reset 0.
  - done_o pulses high for exactly one cycle on the HOLD->IDLE transition.
  - Adds input done_clr_i and output done_sticky_o. done_sticky_o is set with done_o and cleared by done_clr_i; if set and clear occur in the same cycle, set wins.
- When undefined: these ports do not exist and behaviour is otherwise identical.

Decomposition:
- Package pad_mux_seq_pkg:
  - typedef enum logic [1:0] {IDLE, SETTLE, SWITCH, HOLD} pms_state_e.
  - Default constants PMS_CFG_W=6 and PMS_NPADS=32.
- A single sub-module pad_mux_seq_cnt holds the down-counter, with load value, enable and zero flag. Everything else is in the top FSM.

Test Plan:
- Reset mid-sequence: start a change, assert rst_n=0 during SETTLE -> next edge all outputs are 0 and state is IDLE; with rst_n=1 and requests still nonzero, a fresh sequence restarts.
- Single pad mux change, SETTLE_CYC=4, HOLD_CYC=2: mux_req_i 0x0 -> 0x00000004.
  - oen_force_o=0x4 for 7 cycles.
  - pad_mux_o becomes 0x4 six cycles after the request edge.
  - busy_o clears with the force.
  - All other pads are untouched.
- Config-only change: pad 31 cfg 0 -> 6'h2A with mux unchanged -> oen_force_o=0x80000000, pad_cfg_o[31]=6'h2A after the switch, pad_mux_o stays unchanged.
- Request change while busy: pad 1 is requested during SETTLE of a pad-0 sequence -> pad-0 sequence completes unaltered; after one IDLE cycle a second sequence with mask 0x2 runs.
- No-op: request toggles 0->1->0 while busy and equals applied values at IDLE -> no sequence; busy_o stays 0.
- With PAD_MUX_SEQ_DONE_IRQ_EN:
  - done_o is a single-cycle pulse on the HOLD exit.
  - done_sticky_o stays set until done_clr_i.
  - Simultaneous set and clear leaves done_sticky_o=1.

Source files
------------

// File: rtl/pad_mux_seq_pkg.sv
// Shared types and defaults for the pad mux sequencer.
// States of the change sequence plus default pad geometry.
package pad_mux_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SWITCH,
        HOLD
    } pms_state_e;

    localparam int PMS_CFG_W = 6;
    localparam int PMS_NPADS = 32;

endpackage

// File: rtl/pad_mux_seq_cnt.sv
// Down-counter for the settle and hold phases.
// Loads a start value, counts to zero and reports zero.
module pad_mux_seq_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    // Load has priority; decrement stops at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pad_mux_sequencer.sv
// Glitch-free pad mux/config switcher with forced output disable.
// Optional done pulse and sticky flag: PAD_MUX_SEQ_DONE_IRQ_EN.
module pad_mux_sequencer
    import pad_mux_seq_pkg::*;
#(
    parameter int NPADS      = PMS_NPADS,
    parameter int CFG_W      = PMS_CFG_W,
    parameter int SETTLE_CYC = 4,
    parameter int HOLD_CYC   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NPADS-1:0]       mux_req_i,
    input  logic [NPADS*CFG_W-1:0] cfg_req_i,
    output logic [NPADS-1:0]       pad_mux_o,
    output logic [NPADS*CFG_W-1:0] pad_cfg_o,
    output logic [NPADS-1:0]       oen_force_o,
    output logic                   busy_o
`ifdef PAD_MUX_SEQ_DONE_IRQ_EN
   ,input  logic                   done_clr_i
   ,output logic                   done_o
   ,output logic                   done_sticky_o
`endif
);

    localparam int CNT_MAX = (SETTLE_CYC > HOLD_CYC) ? SETTLE_CYC : HOLD_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SET_LD  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC - 1);
    localparam int CW = NPADS * CFG_W;

    pms_state_e state_q, state_d;

    logic [NPADS-1:0] mux_q, mux_d;
    logic [CW-1:0]    cfg_q, cfg_d;
    logic [NPADS-1:0] oen_q, oen_d;
    logic             busy_q, busy_d;
    logic [NPADS-1:0] mux_snap;
    logic [CW-1:0]    cfg_snap;
    logic             snap_en;
    logic [NPADS-1:0] chg;

    logic             cnt_load;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;

    pad_mux_seq_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // Pads whose requested mux or config differs from what is applied.
    always_comb begin
        chg = '0;
        for (int i = 0; i < NPADS; i++) begin
            chg[i] = (mux_req_i[i] != mux_q[i])
                   | (cfg_req_i[i*CFG_W +: CFG_W]
                      != cfg_q[i*CFG_W +: CFG_W]);
        end
    end

    // Next state and next register values for the sequence.
    always_comb begin
        state_d  = state_q;
        mux_d    = mux_q;
        cfg_d    = cfg_q;
        oen_d    = oen_q;
        busy_d   = busy_q;
        snap_en  = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cnt_val  = '0;
        unique case (state_q)
            IDLE: begin
                if (|chg) begin
                    state_d  = SETTLE;
                    snap_en  = 1'b1;
                    oen_d    = chg;
                    busy_d   = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = SET_LD;
                end
            end
            SETTLE: begin
                if (cnt_zero) begin
                    state_d = SWITCH;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            SWITCH: begin
                mux_d    = mux_snap;
                cfg_d    = cfg_snap;
                cnt_load = 1'b1;
                cnt_val  = HOLD_LD;
                state_d  = HOLD;
            end
            HOLD: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                    oen_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_en = 1'b1;
                end
            end
        endcase
    end

    // State, applied outputs and request snapshot registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mux_q    <= '0;
            cfg_q    <= '0;
            oen_q    <= '0;
            busy_q   <= 1'b0;
            mux_snap <= '0;
            cfg_snap <= '0;
        end else begin
            state_q <= state_d;
            mux_q   <= mux_d;
            cfg_q   <= cfg_d;
            oen_q   <= oen_d;
            busy_q  <= busy_d;
            if (snap_en) begin
                mux_snap <= mux_req_i;
                cfg_snap <= cfg_req_i;
            end
        end
    end

    assign pad_mux_o   = mux_q;
    assign pad_cfg_o   = cfg_q;
    assign oen_force_o = oen_q;
    assign busy_o      = busy_q;

`ifdef PAD_MUX_SEQ_DONE_IRQ_EN
    logic done_set;
    logic done_q;
    logic sticky_q;

    assign done_set = (state_q == HOLD) && cnt_zero;

    // One-cycle done pulse and sticky flag; set beats clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            done_q   <= done_set;
            sticky_q <= done_set | (sticky_q & ~done_clr_i);
        end
    end

    assign done_o        = done_q;
    assign done_sticky_o = sticky_q;
`endif

endmodule

// File: tb/tb_pad_mux_sequencer.sv
// Scoreboard bench for pad_mux_sequencer.
// Expected per-cycle outputs are queued at stimulus time.
module tb_pad_mux_sequencer;

    localparam int NP = 32;
    localparam int CW = 6;
    localparam int NC = NP * CW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NP-1:0] mux_req = '0;
    logic [NC-1:0] cfg_req = '0;
    logic [NP-1:0] pad_mux;
    logic [NC-1:0] pad_cfg;
    logic [NP-1:0] oen_force;
    logic          busy;
`ifdef PAD_MUX_SEQ_DONE_IRQ_EN
    logic          done_clr = 1'b0;
    logic          done;
    logic          done_sticky;
`endif

    pad_mux_sequencer #(
        .NPADS      (NP),
        .CFG_W      (CW),
        .SETTLE_CYC (4),
        .HOLD_CYC   (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mux_req_i   (mux_req),
        .cfg_req_i   (cfg_req),
        .pad_mux_o   (pad_mux),
        .pad_cfg_o   (pad_cfg),
        .oen_force_o (oen_force),
        .busy_o      (busy)
`ifdef PAD_MUX_SEQ_DONE_IRQ_EN
       ,.done_clr_i    (done_clr)
       ,.done_o        (done)
       ,.done_sticky_o (done_sticky)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NP-1:0] mux;
        logic [NC-1:0] cfg;
        logic [NP-1:0] oen;
        logic          busy;
        logic          done;
    } exp_t;

    exp_t          sbq[$];
    exp_t          e;
    int            checks = 0;
    int            errors = 0;
    int            nent = 0;
    logic [NP-1:0] cur_mux = '0;
    logic [NC-1:0] cur_cfg = '0;

    task automatic check(input string tag,
                         input logic [255:0] got,
                         input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NP-1:0] mask_of(
        input logic [NP-1:0] ma, input logic [NC-1:0] ca,
        input logic [NP-1:0] mb, input logic [NC-1:0] cb);
        logic [NP-1:0] m;
        m = '0;
        for (int i = 0; i < NP; i++)
            m[i] = (ma[i] != mb[i]) || (ca[i*CW +: CW] != cb[i*CW +: CW]);
        return m;
    endfunction

    task automatic push(input logic [NP-1:0] m, input logic [NC-1:0] c,
                        input logic [NP-1:0] o, input logic b,
                        input logic d);
        exp_t x;
        x.mux = m; x.cfg = c; x.oen = o; x.busy = b; x.done = d;
        sbq.push_back(x);
    endtask

    // Whole sequence: 4 settle + 1 switch with old values, 2 hold with new.
    task automatic push_seq(input logic [NP-1:0] nm,
                            input logic [NC-1:0] nc, input bit lead);
        logic [NP-1:0] m;
        m = mask_of(nm, nc, cur_mux, cur_cfg);
        if (lead) push(cur_mux, cur_cfg, '0, 1'b0, 1'b0);
        repeat (5) push(cur_mux, cur_cfg, m, 1'b1, 1'b0);
        repeat (2) push(nm, nc, m, 1'b1, 1'b0);
        push(nm, nc, '0, 1'b0, 1'b1);
        cur_mux = nm;
        cur_cfg = nc;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sbq.size() > 0) begin
            check("drain_timeout", 256'(sbq.size()), 256'(0));
            sbq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Compare one queued expectation per cycle, away from the edge.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check($sformatf("mux#%0d", nent), 256'(pad_mux), 256'(e.mux));
            check($sformatf("cfg#%0d", nent), 256'(pad_cfg), 256'(e.cfg));
            check($sformatf("oen#%0d", nent), 256'(oen_force), 256'(e.oen));
            check($sformatf("busy#%0d", nent), 256'(busy), 256'(e.busy));
`ifdef PAD_MUX_SEQ_DONE_IRQ_EN
            check($sformatf("done#%0d", nent), 256'(done), 256'(e.done));
`endif
            nent++;
        end
    end

    initial begin
        logic [NP-1:0] m;
        logic [NC-1:0] c;

        repeat (3) @(posedge clk);
        #1;
        check("rst_mux", 256'(pad_mux), 256'(0));
        check("rst_cfg", 256'(pad_cfg), 256'(0));
        check("rst_oen", 256'(oen_force), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        m = 32'h0000_0004;
        mux_req = m;
        push_seq(m, cur_cfg, 1'b1);
        drain();

        c = cur_cfg;
        c[31*CW +: CW] = 6'h2A;
        cfg_req = c;
        push_seq(cur_mux, c, 1'b1);
        drain();

        m = cur_mux | 32'h1;
        mux_req = m;
        push_seq(m, cur_cfg, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        m = m | 32'h2;
        mux_req = m;
        push_seq(m, cur_cfg, 1'b0);
        drain();

        c = cur_cfg;
        c[2*CW +: CW] = 6'h15;
        cfg_req = c;
        push_seq(cur_mux, c, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        mux_req[5] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mux_req[5] = 1'b0;
        repeat (4) push(cur_mux, cur_cfg, '0, 1'b0, 1'b0);
        drain();

        mux_req[3] = 1'b1;
        push(cur_mux, cur_cfg, '0, 1'b0, 1'b0);
        repeat (2) push(cur_mux, cur_cfg, 32'h8, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        push('0, '0, '0, 1'b0, 1'b0);
        cur_mux = '0;
        cur_cfg = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_seq(mux_req, cfg_req, 1'b0);
        drain();

`ifdef PAD_MUX_SEQ_DONE_IRQ_EN
        check("sticky_set", 256'(done_sticky), 256'(1));
        done_clr = 1'b1;
        @(posedge clk);
        #1;
        check("sticky_clr", 256'(done_sticky), 256'(0));
        m = mux_req | 32'h10;
        mux_req = m;
        push_seq(m, cur_cfg, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        check("sticky_set_wins", 256'(done_sticky), 256'(1));
        @(posedge clk);
        #1;
        check("sticky_clr2", 256'(done_sticky), 256'(0));
        done_clr = 1'b0;
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
